bank_group_arbiter: RTL

BANK_GROUP_ARBITER -- requirements
Module: bank_group_arbiter

---
 rtl/bg_arb_pkg.sv | 27 ++
 rtl/bank_group_arbiter_rr_pick.sv | 47 ++++
 rtl/bank_group_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bg_arb_pkg.sv
// ============================================================================
// Module      : bg_arb_pkg
// Description : Shared state encoding, default sizing constants and width
//               helper for the bank-group arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bg_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int c_DEF_NUM_GROUPS = 4;
    localparam int c_DEF_MAX_BURSTS = 8;
    localparam int c_DEF_TIMEOUT    = 64;

    // Bits needed to index or count up to value-1, never less than one.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bank_group_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin search: first set request bit at or
//               after start_idx, wrapping; optionally skips the last position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import bg_arb_pkg::*;
#(
    parameter int NUM_GROUPS = c_DEF_NUM_GROUPS,
    parameter int SEL_W      = clog2_min1(NUM_GROUPS)
) (
    input  logic [NUM_GROUPS-1:0] req_vec,
    input  logic [SEL_W-1:0]      start_idx,
    input  logic                  excl_last,
    output logic [SEL_W-1:0]      pick_idx,
    output logic                  found
);

    int               w_pos_int;
    logic [SEL_W-1:0] w_pos;

    // With excl_last set the search starts at owner+1, so the final position
    // visited is the current owner itself and is skipped.
    always_comb begin
        pick_idx  = '0;
        found     = 1'b0;
        w_pos_int = 0;
        w_pos     = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            w_pos_int = int'(start_idx) + i;
            if (w_pos_int >= NUM_GROUPS) begin
                w_pos_int = w_pos_int - NUM_GROUPS;
            end
            w_pos = SEL_W'(w_pos_int);
            if (!found && req_vec[w_pos] && !(excl_last && (i == NUM_GROUPS - 1))) begin
                found    = 1'b1;
                pick_idx = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bank_group_arbiter.sv
// ============================================================================
// Module      : bank_group_arbiter
// Description : Round-robin grant of one bank group at a time to the burst
//               handler, with burst-quota and inactivity-timeout fairness.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_group_arbiter
    import bg_arb_pkg::*;
#(
    parameter int  NUM_GROUPS = c_DEF_NUM_GROUPS,
    parameter int  MAX_BURSTS = c_DEF_MAX_BURSTS,
    parameter int  TIMEOUT    = c_DEF_TIMEOUT,
    localparam int SEL_W      = clog2_min1(NUM_GROUPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flag,
    input  logic [NUM_GROUPS-1:0] req,
    input  logic [NUM_GROUPS-1:0] done,
    output logic [NUM_GROUPS-1:0] start,
    output logic                  wr_en,
    output logic [SEL_W-1:0]      sel
);

    localparam int BURST_W = clog2_min1(MAX_BURSTS + 1);
    localparam int IDLE_W  = clog2_min1(TIMEOUT + 1);

    localparam logic [SEL_W-1:0]   c_LAST_GROUP = SEL_W'(NUM_GROUPS - 1);
    localparam logic [BURST_W-1:0] c_BURST_LAST = BURST_W'(MAX_BURSTS - 1);
    localparam logic [IDLE_W-1:0]  c_IDLE_MAX   = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0]  c_IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

    arb_state_e         r_state,     w_state_nxt;
    logic [SEL_W-1:0]   r_owner,     w_owner_nxt;
    logic [SEL_W-1:0]   r_ptr,       w_ptr_nxt;
    logic [BURST_W-1:0] r_burst_cnt, w_burst_nxt;
    logic [IDLE_W-1:0]  r_idle_cnt,  w_idle_nxt;

    logic [SEL_W-1:0] w_owner_inc;
    logic [SEL_W-1:0] w_search_start;
    logic             w_search_excl;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_own_req;
    logic             w_own_done;
    logic             w_quota;
    logic             w_timeout;
    logic             w_leave;
    logic             w_wr_en;

    assign w_owner_inc    = (r_owner == c_LAST_GROUP) ? '0 : r_owner + SEL_W'(1);
    assign w_search_excl  = (r_state == ST_GRANT);
    assign w_search_start = w_search_excl ? w_owner_inc : r_ptr;

    assign w_own_req  = req[r_owner];
    assign w_own_done = done[r_owner];
    assign w_quota    = w_own_done && (r_burst_cnt == c_BURST_LAST);
    assign w_timeout  = (TIMEOUT != 0) && (r_idle_cnt == c_IDLE_LAST);
    assign w_leave    = (r_state == ST_GRANT) && (!w_own_req || w_quota || w_timeout);

    rr_pick #(
        .NUM_GROUPS (NUM_GROUPS),
        .SEL_W      (SEL_W)
    ) u_rr_pick (
        .req_vec   (req),
        .start_idx (w_search_start),
        .excl_last (w_search_excl),
        .pick_idx  (w_pick_idx),
        .found     (w_pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_idle_cnt  <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flag && w_pick_found) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_burst_nxt = '0;
                    w_idle_nxt  = '0;
                end
            end
            ST_GRANT: begin
                w_wr_en = 1'b1;
                if (w_leave) begin
                    w_ptr_nxt   = w_owner_inc;
                    w_burst_nxt = '0;
                    w_idle_nxt  = '0;
                    if (flag && w_pick_found) begin
                        w_owner_nxt = w_pick_idx;
                        w_wr_en     = 1'b0;
                    end else if (!(flag && w_own_req)) begin
                        // Nobody left to serve, or handler is full: release.
                        w_state_nxt = ST_IDLE;
                        w_wr_en     = 1'b0;
                    end
                end else if (w_own_done) begin
                    w_burst_nxt = r_burst_cnt + BURST_W'(1);
                    w_idle_nxt  = '0;
                end else if (r_idle_cnt != c_IDLE_MAX) begin
                    w_idle_nxt = r_idle_cnt + IDLE_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign start = (r_state == ST_GRANT) ? (NUM_GROUPS'(1) << r_owner) : '0;
    assign sel   = (r_state == ST_GRANT) ? r_owner : '0;
    assign wr_en = w_wr_en;

endmodule

`default_nettype wire
